// File: rtl/ram_xfer_pkg.sv
// Shared definitions for the RAM transfer engines: FSM state encoding and
// word-count width helper.
package ram_xfer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } xfer_state_e;

    // A count must reach the full depth, so it needs one bit more than an address.
    function automatic int unsigned len_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Registered data/valid output stage of a valid/ready stream.
// A load takes priority over a clear; otherwise both outputs hold.
module stream_out_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (ld_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ram_rd_stream_fsm.sv
// Read-side transfer engine: streams len words from an async-read RAM,
// starting at base_addr with modulo-depth wrap, over a valid/ready interface.
module ram_rd_stream_fsm
    import ram_xfer_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned D    = 16,
    parameter int unsigned DLog = $clog2(D)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [DLog-1:0] base_addr_i,
    input  logic [DLog:0]   len_i,
    output logic [DLog-1:0] addr_rd_o,
    input  logic [W-1:0]    ram_data_i,
    output logic [W-1:0]    m_data_o,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned LenW = len_width(DLog);
    localparam logic [DLog-1:0] PtrLast = DLog'(D - 1);

    xfer_state_e     state_q, state_d;
    logic [DLog-1:0] ptr_q, ptr_d, ptr_inc;
    logic [LenW-1:0] rem_q, rem_d;
    logic            done_q;
    logic            ld, clr;

    // Depth need not be a power of two, so wrap explicitly.
    assign ptr_inc = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        ld      = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ptr_d   = base_addr_i;
                    rem_d   = len_i;
                    state_d = (len_i == '0) ? StFin : StRead;
                end
            end
            StRead: begin
                ld = (rem_q != '0) && (!m_valid_o || m_ready_i);
                if (ld) begin
                    ptr_d = ptr_inc;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LenW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (m_valid_o && m_ready_i) begin
                    clr     = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            // Pulse lands in the cycle after FIN, once the engine is idle again.
            done_q  <= (state_q == StFin);
        end
    end

    stream_out_reg #(
        .W (W)
    ) u_stream_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ld_i    (ld),
        .clr_i   (clr),
        .data_i  (ram_data_i),
        .data_o  (m_data_o),
        .valid_o (m_valid_o)
    );

    assign addr_rd_o = ptr_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;

endmodule
